// File: rtl/mem_wb_reg_pkg.sv
// Shared RV32I types for the MEM/WB stage: load funct3 codes, MEM/WB FSM
// states and the packed writeback bundle.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } mem_wb_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg_load_fmt.sv
// Combinational load-data extraction: picks the byte/half/word addressed by
// the low address bits and sign- or zero-extends it according to funct3.
module load_fmt
  import rv32i_types::*;
(
  input  logic [31:0] src,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = src[8*offset +: 8];
    // Halves ignore offset[0]: misaligned accesses are silently aligned down.
    half_sel = offset[1] ? src[31:16] : src[15:0];
    data     = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = src;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with D-cache response hold and load formatting.
// Optional MEM_WB_PERF_EN adds memory-stall and memory-op counters.
module mem_wb_reg
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_mem_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        rd_we,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_rdata_d,
  input  logic        mem_rdy,
  input  logic        stall_in,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0] perf_mem_stall_cycles,
  output logic [31:0] perf_mem_ops
`endif
);

  mem_wb_state_t state, state_next;
  logic [31:0]   hold_q;
  logic [31:0]   src;
  logic [31:0]   load_data;
  logic [31:0]   fmt;
  logic          memop;
  logic          advance;
  logic          capture;
  mem_wb_t       wb_q;

  assign memop     = exe_mem_valid & (is_load | is_store);
  assign mem_stall = memop & ~mem_rdy & (state != HELD);
  assign mem_done  = (state == HELD);
  assign advance   = ~stall_in & ~mem_stall;
  assign src       = (state == HELD) ? hold_q : mem_rdata_d;

  load_fmt u_load_fmt (
    .src    (src),
    .offset (alu_out[1:0]),
    .funct3 (funct3),
    .data   (load_data)
  );

  assign fmt = is_load ? load_data : alu_out;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (memop && !mem_rdy) begin
          state_next = WAIT;
        end else if (memop && mem_rdy && stall_in) begin
          state_next = HELD;
          capture    = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rdy && stall_in) begin
          state_next = HELD;
          capture    = 1'b1;
        end else if (mem_rdy) begin
          state_next = IDLE;
        end
      end
      HELD: begin
        if (!stall_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
    end else begin
      state <= state_next;
      if (capture) hold_q <= mem_rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else if (advance) begin
      wb_q.valid <= exe_mem_valid;
      wb_q.rd    <= rd;
      wb_q.we    <= rd_we;
      wb_q.data  <= fmt;
    end
  end

  assign wb_valid = wb_q.valid;
  assign wb_rd    = wb_q.rd;
  assign wb_we    = wb_q.valid & wb_q.we;
  assign wb_data  = wb_q.data;

`ifdef MEM_WB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mem_stall_cycles <= '0;
      perf_mem_ops          <= '0;
    end else begin
      if (mem_stall)         perf_mem_stall_cycles <= perf_mem_stall_cycles + 32'd1;
      if (advance && memop)  perf_mem_ops          <= perf_mem_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: expected WB bundles are queued when a
// transaction is driven and compared after the edge that retires it.
module tb_mem_wb_reg;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        exe_mem_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        rd_we;
  logic [31:0] alu_out;
  logic [31:0] mem_rdata_d;
  logic        mem_rdy;
  logic        stall_in;
  logic        mem_stall;
  logic        mem_done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
`ifdef MEM_WB_PERF_EN
  logic [31:0] perf_mem_stall_cycles;
  logic [31:0] perf_mem_ops;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  mem_wb_t     sb[$];
  mem_wb_t     exp_e;
  mem_wb_t     got_e;

  mem_wb_reg dut (
    .clk           (clk),
    .rst           (rst),
    .exe_mem_valid (exe_mem_valid),
    .is_load       (is_load),
    .is_store      (is_store),
    .funct3        (funct3),
    .rd            (rd),
    .rd_we         (rd_we),
    .alu_out       (alu_out),
    .mem_rdata_d   (mem_rdata_d),
    .mem_rdy       (mem_rdy),
    .stall_in      (stall_in),
    .mem_stall     (mem_stall),
    .mem_done      (mem_done),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_mem_stall_cycles (perf_mem_stall_cycles),
    .perf_mem_ops          (perf_mem_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the load formatter, written with shifts.
  function automatic logic [31:0] model_fmt(input logic ld, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] s);
    logic [31:0] b;
    logic [31:0] h;
    if (!ld) return a;
    b = s >> (a[1:0] * 8);
    h = s >> (a[1] * 16);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'd0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'd0, h[15:0]};
      3'b010:  return s;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] r, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic stl);
    exe_mem_valid = v;
    is_load       = ld;
    is_store      = st;
    funct3        = f3;
    rd            = r;
    rd_we         = we;
    alu_out       = a;
    mem_rdata_d   = d;
    mem_rdy       = rdy;
    stall_in      = stl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data} !== 39'd0) begin
      errors++;
      $display("FAIL reset_wb: got v=%b we=%b rd=%0d data=%h, want all zero",
               wb_valid, wb_we, wb_rd, wb_data);
    end
    checks++;
    if ({mem_done, mem_stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: got done=%b stall=%b, want 0 0", mem_done, mem_stall);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lb();
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 1'b1, 32'h0000_1003, 32'h80FF_1234, 1'b1, 1'b0);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL lb_stall: got %b want 0", mem_stall);
    end
    sb.push_back('{valid: 1'b1, rd: 5'd5, we: 1'b1, data: 32'hFFFF_FF80});
    @(posedge clk);
    #1;
    got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL lb_wb: scoreboard empty");
    end else begin
      exp_e = sb.pop_front();
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL lb_wb: got %h want %h", got_e, exp_e);
      end
    end
    drive_idle();
  endtask

  task automatic test_lhu_late();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'b101, 5'd7, 1'b1, 32'h0000_1002, 32'h8001_7FFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL lhu_stall[%0d]: got stall=%b wb_valid=%b want 1 0", i, mem_stall, wb_valid);
      end
      @(posedge clk);
      #1;
    end
    mem_rdy = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL lhu_rdy_stall: got %b want 0", mem_stall);
    end
    sb.push_back('{valid: 1'b1, rd: 5'd7, we: 1'b1, data: 32'h0000_8001});
    @(posedge clk);
    #1;
    got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL lhu_wb: scoreboard empty");
    end else begin
      exp_e = sb.pop_front();
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL lhu_wb: got %h want %h", got_e, exp_e);
      end
    end
`ifdef MEM_WB_PERF_EN
    checks++;
    if (perf_mem_stall_cycles !== 32'd3 || perf_mem_ops !== 32'd1) begin
      errors++;
      $display("FAIL perf: got stall_cycles=%0d ops=%0d want 3 1", perf_mem_stall_cycles, perf_mem_ops);
    end
`endif
    drive_idle();
  endtask

  task automatic test_held();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1;
    checks++;
    if (mem_stall !== 1'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL held_issue: got stall=%b done=%b want 0 0", mem_stall, mem_done);
    end
    @(posedge clk);
    #1;
    mem_rdy     = 1'b0;
    mem_rdata_d = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_in = 1'b0;
      #1;
      checks++;
      if (mem_done !== 1'b1 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL held_done[%0d]: got done=%b stall=%b want 1 0", i, mem_done, mem_stall);
      end
      if (i == 3) sb.push_back('{valid: 1'b1, rd: 5'd9, we: 1'b1, data: 32'hDEAD_BEEF});
      @(posedge clk);
      #1;
    end
    got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL held_wb: scoreboard empty");
    end else begin
      exp_e = sb.pop_front();
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL held_wb: got %h want %h", got_e, exp_e);
      end
    end
    checks++;
    if (mem_done !== 1'b0) begin
      errors++;
      $display("FAIL held_release: got done=%b want 0", mem_done);
    end
    drive_idle();
  endtask

  task automatic test_store();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 1'b0, 32'h0000_2000, 32'hAAAA_5555, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mem_stall !== 1'b1) begin
        errors++;
        $display("FAIL store_stall[%0d]: got %b want 1", i, mem_stall);
      end
      @(posedge clk);
      #1;
    end
    mem_rdy = 1'b1;
    sb.push_back('{valid: 1'b1, rd: 5'd3, we: 1'b0, data: 32'h0000_2000});
    @(posedge clk);
    #1;
    got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL store_wb: scoreboard empty");
    end else begin
      exp_e = sb.pop_front();
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL store_wb: got %h want %h", got_e, exp_e);
      end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic        t_ld [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    logic [2:0]  t_f3 [9] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b010, 3'b011, 3'b000, 3'b000, 3'b101};
    logic [31:0] t_a  [9] = '{32'h1, 32'h2, 32'h3, 32'h1, 32'h6, 32'h0, 32'hCAFE_BABE, 32'h2, 32'h0};
    logic [31:0] t_d  [9] = '{32'h0000_8000, 32'h8001_0000, 32'h8001_0000, 32'h1234_8765,
                              32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h1111_1111, 32'h007F_0000, 32'h0000_F00D};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, t_ld[i], 1'b0, t_f3[i], 5'(i + 10), (i != 8), t_a[i], t_d[i], 1'b1, 1'b0);
      sb.push_back('{valid: 1'b1, rd: 5'(i + 10), we: (i != 8),
                     data: model_fmt(t_ld[i], t_f3[i], t_a[i], t_d[i])});
      @(posedge clk);
      #1;
      got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_wb[%0d]: scoreboard empty", i);
      end else begin
        exp_e = sb.pop_front();
        checks++;
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL b2b_wb[%0d]: got %h want %h", i, got_e, exp_e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd21, 1'b1, 32'h0000_4000, 32'h0BAD_F00D, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL wait_stall: got %b want 1", mem_stall);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data, mem_done} !== 40'd0) begin
      errors++;
      $display("FAIL async_rst: got v=%b we=%b rd=%0d data=%h done=%b want all zero",
               wb_valid, wb_we, wb_rd, wb_data, mem_done);
    end
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd4, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    sb.push_back('{valid: 1'b0, rd: 5'd4, we: 1'b0, data: 32'd0});
    @(posedge clk);
    #1;
    got_e = '{valid: wb_valid, rd: wb_rd, we: wb_we, data: wb_data};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bubble_wb: scoreboard empty");
    end else begin
      exp_e = sb.pop_front();
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL bubble_wb: got %h want %h", got_e, exp_e);
      end
    end
    checks++;
    if (mem_done !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL bubble_ctrl: got done=%b stall=%b want 0 0", mem_done, mem_stall);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_late();
    test_held();
    test_store();
    test_back_to_back();
    test_reset_mid_wait();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

MEM/WB pipeline register and load-data formatter, directly downstream of the memory stage. It holds the MEM instruction until its D-cache response arrives and captures the response if the rest of the pipeline is stalled at that moment. It then extracts and extends the load byte, half or word and presents the writeback value, destination register and write enable to the WB stage. It generates the memory-stall term used by the hazard/control unit.

## Interface
Parameters:
- none (widths come from `rv32i_types`)

Ports:
- `clk` in 1 — core clock.
- `rst` in 1 — asynchronous, active-high reset.
- `exe_mem_valid` in 1 — EXE_MEM register holds a live instruction.
- `is_load` in 1 — `ctrl_w_MEM.mem_read_d`.
- `is_store` in 1 — `ctrl_w_MEM.mem_write_d`.
- `funct3` in 3 — load width/sign code.
- `rd` in 5 — destination register.
- `rd_we` in 1 — instruction writes `rd`.
- `alu_out` in 32 — ALU result; also the byte address for memory ops.
- `mem_rdata_d` in 32 — D-cache read data, valid when `mem_rdy`.
- `mem_rdy` in 1 — from memory stage; response this cycle.
- `stall_in` in 1 — global stall from other sources (I-cache miss etc.).
- `mem_stall` out 1 — MEM waiting on D-cache; stalls all earlier stages.
- `mem_done` out 1 — response already captured; memory stage must drop its request.
- `wb_valid` out 1 — WB holds a live instruction.
- `wb_rd` out 5 — destination register.
- `wb_we` out 1 — register-file write enable (`wb_valid & rd_we`).
- `wb_data` out 32 — writeback value.

## Operation
- `memop = exe_mem_valid & (is_load | is_store)`.
- FSM states:
  - **IDLE** — no outstanding op.
  - **WAIT** — op issued, no response yet.
  - **HELD** — response captured while `stall_in` is high.
- FSM transitions:
  - IDLE: `memop & !mem_rdy` → WAIT.
  - IDLE: `memop & mem_rdy & stall_in` → HELD, capture `mem_rdata_d` into `hold_q`.
  - IDLE: otherwise stay in IDLE.
  - WAIT: `mem_rdy & stall_in` → HELD, capture.
  - WAIT: `mem_rdy & !stall_in` → IDLE.
  - WAIT: otherwise stay in WAIT.
  - HELD: `!stall_in` → IDLE.
- `mem_stall = memop & !mem_rdy & (state != HELD)`.
- `mem_done = (state == HELD)`.
- `advance = !stall_in & !mem_stall`. On `advance`:
  - `wb_valid <= exe_mem_valid`
  - `wb_rd <= rd`
  - `rd_we_q <= rd_we`
  - `wb_data <= fmt`
- Load source word `src = (state == HELD) ? hold_q : mem_rdata_d`. Byte offset `o = alu_out[1:0]`.
- `fmt` by `funct3` for loads:
  - 000 LB: sign-extend `src[8*o +: 8]`.
  - 100 LBU: zero-extend `src[8*o +: 8]`.
  - 001 LH: sign-extend `src[16*o[1] +: 16]`.
  - 101 LHU: zero-extend `src[16*o[1] +: 16]`.
  - 010 LW: `src`.
  - Any other code: 0.
- Misaligned halves/words ignore the low offset bits; no trap is raised.
- Non-loads, including stores: `fmt = alu_out`. Stores are issued with `rd_we = 0` by decode.
- `exe_mem_valid = 0` with `advance` inserts a bubble: `wb_valid = 0`, `wb_we = 0`.

## Timing
- `mem_stall` and `fmt` are combinational from `mem_rdy`/`mem_rdata_d` in the same cycle. The result is registered at the next `posedge clk`.
- Load latency: the WB value is visible one cycle after the `mem_rdy` cycle when `stall_in` is low. When `stall_in` is high, it is visible one cycle after `stall_in` falls.
- `mem_rdy` is a single-cycle pulse. `hold_q` is the only copy of the data once the FSM is in HELD.
- Simultaneous `mem_rdy` and `stall_in` always capture; data is never lost.
- Reset (asynchronous, at any time, including in WAIT or HELD) clears:
  - the FSM to IDLE
  - `hold_q`, `wb_valid`, `wb_we`, `wb_rd`, `wb_data` to 0.
- Reset values of combinational outputs: `mem_stall` follows its equation; `mem_done` = 0.
- `mem_rdy` seen in IDLE without `memop` is ignored.

## Configuration
- `MEM_WB_PERF_EN` defined: adds two 32-bit output ports.
  - `perf_mem_stall_cycles` counts cycles with `mem_stall = 1`.
  - `perf_mem_ops` counts memops retired on `advance`.
  - Both counters reset to 0 and wrap modulo 2^32.
- `MEM_WB_PERF_EN` undefined: no counters and no ports. Behaviour is otherwise identical.

## Structure
- `rv32i_types` holds:
  - the load `funct3` enum (lb, lh, lw, lbu, lhu)
  - a `mem_wb_state_t` enum {IDLE, WAIT, HELD}
  - a packed `mem_wb_t` struct (valid, rd, we, data).
- One sub-module, `load_fmt`: purely combinational extraction of (`src`, offset, `funct3`) → 32-bit value.

## Test plan
- LB at `alu_out` = 0x1003, `mem_rdata_d` = 0x80FF_1234, `mem_rdy` in the issue cycle → next cycle `wb_data` = 0xFFFF_FF80, `wb_we` = 1, `mem_stall` = 0.
- LHU at `alu_out` = 0x1002, data 0x8001_7FFF, `mem_rdy` 3 cycles late → `mem_stall` = 1 for 3 cycles, then `wb_data` = 0x0000_8001.
- LW with `mem_rdy` and `stall_in` both high, `stall_in` held 4 cycles, `mem_rdata_d` changed to garbage → `mem_done` = 1 for 4 cycles; after release `wb_data` = the captured word.
- Store (`rd_we` = 0) with `alu_out` = 0x2000, `mem_rdy` after 2 cycles → `wb_valid` = 1, `wb_we` = 0; no register-file write.
- `rst` pulsed mid-WAIT → all outputs 0 immediately, FSM back in IDLE; a later `mem_rdy` with `exe_mem_valid` = 0 yields `wb_valid` = 0.
- `MEM_WB_PERF_EN` build: the scenario with the 3-cycle stall → `perf_mem_stall_cycles` = 3, `perf_mem_ops` = 1.
